an_tradeoff_decoder: RTL and testbench

- Parametrised successor to the fixed A=6311, 20-bit trade-off AN-code decoder.
- Takes a codeword W = A*N + e over a valid/ready stream. Corrects single arithmetic errors e = ±2^k and, optionally, double errors ±2^i ± 2^j. Returns N with a status code.
- Hard-coded l/r LUTs are replaced by a power-residue table built after reset, plus parallel comparators.
- Hardware dividers are replaced by sequential reduction and division.

---
 rtl/an_tradeoff_decoder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_an_tradeoff_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/an_tradeoff_decoder.sv
// Sequential AN-code decoder: corrects single (and, with AN_DOUBLE_CORR_EN defined,
// double) arithmetic errors in W = A*N + e and returns N with a status code.
module an_tradeoff_decoder #(
  parameter int A      = 6311,
  parameter int A_BITS = 13,
  parameter int W_BITS = 34,
  parameter int N_BITS = 21,
  parameter int P_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] W,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] N,
  output logic [1:0]        status,
  output logic [P_BITS-1:0] pos1,
  output logic              sign1,
  output logic [P_BITS-1:0] pos2,
  output logic              sign2
);

  localparam logic [A_BITS:0]   A_EXT = A[A_BITS:0];
  localparam logic [A_BITS-1:0] A_R   = A[A_BITS-1:0];
  localparam int                EW    = W_BITS + 2;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;
  localparam logic [1:0] ST_BAD    = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RES, S_SEC, S_SRCH, S_CORR, S_DIV, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [P_BITS-1:0] cnt;
  logic              cnt_last;
  logic [A_BITS-1:0] p [W_BITS];
  logic [A_BITS-1:0] r;
  logic [W_BITS-1:0] w_reg;
  logic [W_BITS-1:0] quo;

  assign cnt_last  = (cnt == P_BITS'(W_BITS - 1));
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  // One shared "2r + bit mod A" step serves table build, residue and division.
  logic              in_bit;
  logic [A_BITS:0]   trial, trial_diff;
  logic              trial_ge;
  logic [A_BITS-1:0] step_r;
  logic [W_BITS-1:0] quo_nxt;

  always_comb begin
    in_bit     = (state == S_INIT) ? 1'b0 : quo[W_BITS-1];
    trial      = {r, in_bit};
    trial_ge   = (trial >= A_EXT);
    trial_diff = trial - A_EXT;
    step_r     = trial_ge ? trial_diff[A_BITS-1:0] : trial[A_BITS-1:0];
    quo_nxt    = {quo[W_BITS-2:0], trial_ge};
  end

  logic              sec_hit;
  logic [P_BITS-1:0] sec_pos;
  logic              sec_sign;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sec_hit  = 1'b0;
    sec_pos  = '0;
    sec_sign = 1'b0;
    for (int k = W_BITS - 1; k >= 0; k--) begin
      if (r == p[k]) begin
        sec_hit  = 1'b1;
        sec_pos  = P_BITS'(k);
        sec_sign = 1'b1;
      end else if (r == A_R - p[k]) begin
        sec_hit  = 1'b1;
        sec_pos  = P_BITS'(k);
        sec_sign = 1'b0;
      end
    end
  end

`ifdef AN_DOUBLE_CORR_EN
  logic              srch_neg;
  logic [A_BITS-1:0] p_i, t_sub, tgt;
  logic [A_BITS:0]   t_add;
  logic              srch_hit;
  logic [P_BITS-1:0] srch_pos;
  logic              srch_sign;

  always_comb begin
    p_i   = p[cnt];
    t_sub = r - p_i;
    if (r < p_i) t_sub = t_sub + A_R;
    t_add = {1'b0, r} + {1'b0, p_i};
    if (t_add >= A_EXT) t_add = t_add - A_EXT;
    tgt       = srch_neg ? t_add[A_BITS-1:0] : t_sub;
    srch_hit  = 1'b0;
    srch_pos  = '0;
    srch_sign = 1'b0;
    for (int j = W_BITS - 1; j >= 0; j--) begin
      if (j > int'(cnt)) begin
        if (tgt == p[j]) begin
          srch_hit  = 1'b1;
          srch_pos  = P_BITS'(j);
          srch_sign = 1'b1;
        end else if (tgt == A_R - p[j]) begin
          srch_hit  = 1'b1;
          srch_pos  = P_BITS'(j);
          srch_sign = 1'b0;
        end
      end
    end
  end
`endif

  // Corrected word in two spare bits so both underflow and overflow show up on top.
  logic [EW-1:0] mag1, mag2, e_val, wc;
  logic          wc_ok;

  always_comb begin
    mag1  = EW'(1) << pos1;
    mag2  = EW'(1) << pos2;
    e_val = '0;
    if (status == ST_SINGLE || status == ST_DOUBLE) e_val = sign1 ? mag1 : -mag1;
    if (status == ST_DOUBLE) e_val = e_val + (sign2 ? mag2 : -mag2);
    wc    = EW'(w_reg) - e_val;
    wc_ok = (wc[EW-1:W_BITS] == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (cnt_last) state_nxt = S_IDLE;
      S_IDLE: if (in_valid) state_nxt = S_RES;
      S_RES:  if (cnt_last) state_nxt = S_SEC;
      S_SEC: begin
        if (r == '0 || sec_hit) state_nxt = S_CORR;
`ifdef AN_DOUBLE_CORR_EN
        else state_nxt = S_SRCH;
`else
        else state_nxt = S_CORR;
`endif
      end
`ifdef AN_DOUBLE_CORR_EN
      S_SRCH: if (srch_hit || (srch_neg && cnt_last)) state_nxt = S_CORR;
`endif
      S_CORR: state_nxt = S_DIV;
      S_DIV:  if (cnt_last) state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // NOTE: the power-residue table has no reset; INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (!rst && state == S_INIT) p[cnt] <= r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      r      <= A_BITS'(1);
      w_reg  <= '0;
      quo    <= '0;
      N      <= '0;
      status <= ST_CLEAN;
      pos1   <= '0;
      sign1  <= 1'b0;
      pos2   <= '0;
      sign2  <= 1'b0;
`ifdef AN_DOUBLE_CORR_EN
      srch_neg <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          r   <= step_r;
          cnt <= cnt_last ? '0 : cnt + P_BITS'(1);
        end
        S_IDLE: if (in_valid) begin
          w_reg  <= W;
          quo    <= W;
          r      <= '0;
          cnt    <= '0;
          status <= ST_CLEAN;
          pos1   <= '0;
          sign1  <= 1'b0;
          pos2   <= '0;
          sign2  <= 1'b0;
        end
        S_RES: begin
          r   <= step_r;
          quo <= {quo[W_BITS-2:0], 1'b0};
          cnt <= cnt_last ? '0 : cnt + P_BITS'(1);
        end
        S_SEC: begin
          if (r == '0) begin
            status <= ST_CLEAN;
          end else if (sec_hit) begin
            status <= ST_SINGLE;
            pos1   <= sec_pos;
            sign1  <= sec_sign;
          end else begin
`ifdef AN_DOUBLE_CORR_EN
            cnt      <= '0;
            srch_neg <= 1'b0;
`else
            status <= ST_BAD;
`endif
          end
        end
`ifdef AN_DOUBLE_CORR_EN
        S_SRCH: begin
          if (srch_hit) begin
            status <= ST_DOUBLE;
            pos1   <= cnt;
            sign1  <= ~srch_neg;
            pos2   <= srch_pos;
            sign2  <= srch_sign;
          end else if (srch_neg && cnt_last) begin
            status <= ST_BAD;
          end else if (srch_neg) begin
            srch_neg <= 1'b0;
            cnt      <= cnt + P_BITS'(1);
          end else begin
            srch_neg <= 1'b1;
          end
        end
`endif
        S_CORR: begin
          r   <= '0;
          cnt <= '0;
          if (wc_ok) begin
            quo <= wc[W_BITS-1:0];
          end else begin
            quo    <= w_reg;
            status <= ST_BAD;
            pos1   <= '0;
            sign1  <= 1'b0;
            pos2   <= '0;
            sign2  <= 1'b0;
          end
        end
        S_DIV: begin
          r   <= step_r;
          quo <= quo_nxt;
          cnt <= cnt_last ? '0 : cnt + P_BITS'(1);
          if (cnt_last) begin
            N <= quo_nxt[N_BITS-1:0];
            if (|quo_nxt[W_BITS-1:N_BITS]) begin
              status <= ST_BAD;
              pos1   <= '0;
              sign1  <= 1'b0;
              pos2   <= '0;
              sign2  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_tradeoff_decoder.sv
// Directed self-checking bench for an_tradeoff_decoder (A=6311, 34-bit codewords).
module tb_an_tradeoff_decoder;

  localparam int W_BITS = 34;
  localparam int N_BITS = 21;
  localparam int P_BITS = 6;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready;
  logic [W_BITS-1:0] W;
  logic [N_BITS-1:0] N;
  logic [1:0]        status;
  logic [P_BITS-1:0] pos1, pos2;
  logic              sign1, sign2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  an_tradeoff_decoder #(
    .A(6311), .A_BITS(13), .W_BITS(W_BITS), .N_BITS(N_BITS), .P_BITS(P_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .W(W),
    .out_valid(out_valid), .out_ready(out_ready), .N(N), .status(status),
    .pos1(pos1), .sign1(sign1), .pos2(pos2), .sign2(sign2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until in_ready rises after a reset release.
  task automatic wait_init(input string tag);
    int n = 0;
    int ov_seen = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
      if (out_valid) ov_seen++;
    end
    check({tag, "_cycles"}, 64'(n), 64'd34);
    check({tag, "_no_ov"}, 64'(ov_seen), 64'd0);
  endtask

  // Returns latency in cycles with the handshake cycle counted as T (out_valid at T+lat).
  task automatic send_word(input logic [W_BITS-1:0] w, output int lat);
    int g = 0;
    int n = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    W        = w;
    in_valid = 1'b1;
    check("accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 400) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic expect_result(input string tag, input int lat, input int exp_lat,
                               input logic [N_BITS-1:0] en, input logic [1:0] est,
                               input int ep1, input logic es1, input int ep2, input logic es2);
    check({tag, "_lat"},   64'(lat),   64'(exp_lat));
    check({tag, "_N"},     64'(N),     64'(en));
    check({tag, "_st"},    64'(status), 64'(est));
    check({tag, "_pos1"},  64'(pos1),  64'(ep1));
    check({tag, "_sign1"}, 64'(sign1), 64'(es1));
    check({tag, "_pos2"},  64'(pos2),  64'(ep2));
    check({tag, "_sign2"}, 64'(sign2), 64'(es2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"},    64'(in_ready),  64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    W         = '0;
    repeat (3) tick();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_N",         64'(N),         64'd0);
    check("rst_status",    64'(status),    64'd0);
    check("rst_pos",       64'({pos1, pos2}), 64'd0);
    check("rst_sign",      64'({sign1, sign2}), 64'd0);
    rst = 1'b0;
    wait_init("init");

    send_word(34'd6311000, lat);
    expect_result("clean", lat, 71, 21'd1000, 2'b00, 0, 1'b0, 0, 1'b0);

    send_word(34'd6311032, lat);
    expect_result("plus5", lat, 71, 21'd1000, 2'b01, 5, 1'b1, 0, 1'b0);

    send_word(34'd6294616, lat);
    expect_result("minus14", lat, 71, 21'd1000, 2'b01, 14, 1'b0, 0, 1'b0);

`ifdef AN_DOUBLE_CORR_EN
    send_word(34'd7359584, lat);
    expect_result("double", lat, 78, 21'd1000, 2'b10, 3, 1'b1, 20, 1'b1);
`else
    send_word(34'd7359584, lat);
    expect_result("double", lat, 71, 21'd1166, 2'b11, 0, 1'b0, 0, 1'b0);
`endif

    // Back-pressure: result must hold while a second word waits.
    send_word(34'd6311032, lat);
    check("stall_lat", 64'(lat), 64'd71);
    W        = 34'd6311000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_ov",   64'(out_valid), 64'd1);
      check("stall_rdy",  64'(in_ready),  64'd0);
      check("stall_N",    64'(N),         64'd1000);
      check("stall_st",   64'(status),    64'd1);
      check("stall_pos1", 64'(pos1),      64'd5);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_ov_drop", 64'(out_valid), 64'd0);
    check("hs_idle",    64'(in_ready),  64'd1);
    tick();
    in_valid = 1'b0;
    check("second_taken", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 400) begin
      tick();
      n++;
    end
    expect_result("second", n + 1, 71, 21'd1000, 2'b00, 0, 1'b0, 0, 1'b0);

    // Reset in the middle of division aborts the word and rebuilds the table.
    W        = 34'd6311032;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (45) tick();
    check("mid_div_ov", 64'(out_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_N",     64'(N),        64'd0);
    check("mid_rst_st",    64'(status),   64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    wait_init("reinit");

    send_word(34'd0, lat);
    expect_result("zero", lat, 71, 21'd0, 2'b00, 0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
